multi_cycle_div: RTL and testbench
==================================

MULTI_CYCLE_DIV -- requirements
Module: multi_cycle_div

Interface
REQ-001 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have a port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have a port start, input, 1 bit: the EX stage holds a divide instruction; held high for as long as that instruction sits in EX.
REQ-004 The block SHALL have a port signed_div, input, 1 bit: 1 selects DIV, 0 selects DIVU; sampled with start.
REQ-005 The block SHALL have a port dividend, input, 32 bits: operand A; sampled with start.
REQ-006 The block SHALL have a port divisor, input, 32 bits: operand B; sampled with start.
REQ-007 The block SHALL have a port flush, input, 1 bit: cancels any divide in progress.
REQ-008 The block SHALL have a port request_stall, output, 1 bit: stall request to the pipeline controller, which freezes pc/if/id.
REQ-009 The block SHALL have a port done, output, 1 bit: one-cycle pulse; results valid.
REQ-010 The block SHALL have a port quotient, output, 32 bits: result, written to LO.
REQ-011 The block SHALL have a port remainder, output, 32 bits: result, written to HI.

Function
REQ-012 The block SHALL use the states IDLE, BUSY and DONE, with a 6-bit iteration counter.
REQ-013 In IDLE with start=1 and flush=0, the block SHALL latch the operand magnitudes, the quotient sign (A[31]^B[31] when signed) and the remainder sign (A[31] when signed), then go to BUSY (count=0) if divisor!=0, otherwise go to DONE.
REQ-014 In BUSY, the block SHALL perform one restoring shift-subtract step per cycle, increment the counter, and go to DONE after the 32nd step.
REQ-015 In DONE, done SHALL be 1, quotient and remainder SHALL hold sign-corrected results, and the next state SHALL be IDLE unconditionally; start is not re-sampled in DONE.
REQ-016 request_stall SHALL equal (state==IDLE and start and not flush) or state==BUSY; it is combinational and low in DONE, so the pipeline advances during the done cycle.
REQ-017 Latency: with start accepted in cycle N, request_stall SHALL be high in cycles N..N+32 (33 cycles) and done SHALL be high in cycle N+33.
REQ-018 On divide by zero, the block SHALL skip the iterations (done at N+1, request_stall high in cycle N only), with quotient=32'hFFFF_FFFF and remainder=dividend, regardless of signed_div.
REQ-019 Signed overflow (0x8000_0000 / 0xFFFF_FFFF) SHALL yield quotient=0x8000_0000 and remainder=0, with normal latency.
REQ-020 flush=1 in any state SHALL force IDLE on the next edge; done SHALL be 0 and request_stall 0 in that cycle, and no result is produced.
REQ-021 quotient and remainder SHALL hold their last DONE values until the next DONE; the block SHALL not drive intermediate values onto them.
REQ-022 All arithmetic SHALL be 32-bit unsigned on magnitudes, using a 33-bit partial-remainder subtract; negation is two's complement modulo 2^32.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL enter IDLE with counter=0, quotient=0, remainder=0 and all internal operand registers cleared.
REQ-024 While rst=1, request_stall and done SHALL be 0 irrespective of start or flush; rst mid-BUSY abandons the operation.
REQ-025 rst SHALL take priority over flush, and flush SHALL take priority over start.

Structure
REQ-026 The shared include bus.v SHALL provide the data width, the HI/LO bus widths and the state encoding constants; the block SHALL not define local literals for these.
REQ-027 The block SHALL be a single module with no sub-module required; the pipeline controller SHALL OR request_stall with existing stall requests.

Verification
REQ-028 The bench SHALL cover: unsigned 100/7 with start held -> request_stall high 33 cycles, done at N+33, quotient=14, remainder=2.
REQ-029 The bench SHALL cover: signed -7/2 -> quotient=0xFFFF_FFFD (-3), remainder=0xFFFF_FFFF (-1).
REQ-030 The bench SHALL cover: 0x1234/0 -> done at N+1, quotient=0xFFFF_FFFF, remainder=0x1234.
REQ-031 The bench SHALL cover: signed 0x8000_0000/0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0.
REQ-032 The bench SHALL cover: flush in cycle N+10 -> IDLE at N+11, request_stall 0 from N+10 and no done pulse; a new start at N+12 completes normally.
REQ-033 The bench SHALL cover: rst asserted mid-BUSY -> all outputs 0 the next cycle, then back-to-back divides with start held through DONE -> exactly one done pulse per instruction.

Source files
------------

// File: rtl/multi_cycle_div_pkg.sv
// Shared widths, FSM encoding and sign helpers for the multi-cycle divider.
package multi_cycle_div_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int HI_W   = DATA_W;
  localparam int LO_W   = DATA_W;

  localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] val,
                                                 input logic             neg);
    cond_neg = neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/multi_cycle_div_if.sv
// Pipeline-to-divider handshake and result bus.
interface multi_cycle_div_if;
  import multi_cycle_div_pkg::*;

  logic              start;
  logic              signed_div;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              flush;
  logic              request_stall;
  logic              done;
  logic [LO_W-1:0]   quotient;
  logic [HI_W-1:0]   remainder;

  modport master (
    output start, signed_div, dividend, divisor, flush,
    input  request_stall, done, quotient, remainder
  );

  modport slave (
    input  start, signed_div, dividend, divisor, flush,
    output request_stall, done, quotient, remainder
  );

endinterface

// File: rtl/multi_cycle_div.sv
// Restoring 32-bit DIV/DIVU unit: one shift-subtract step per cycle, results
// held in registers from the DONE cycle until the next completed divide.
module multi_cycle_div
  import multi_cycle_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  multi_cycle_div_if.slave bus
);

  div_state_e        state_r;
  div_state_e        state_s;
  logic [CNT_W-1:0]  count_r;
  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] mag_b_r;
  logic              q_neg_r;
  logic              r_neg_r;
  logic [LO_W-1:0]   quotient_r;
  logic [HI_W-1:0]   remainder_r;

  logic              accept_s;
  logic              div_zero_s;
  logic              last_step_s;
  logic [DATA_W:0]   shifted_s;
  logic [DATA_W:0]   diff_s;
  logic [DATA_W-1:0] quo_next_s;
  logic [DATA_W-1:0] rem_next_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; flush overrides everything except reset.
  always_comb begin
    state_s = state_r;
    if (bus.flush) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_s = div_zero_s ? ST_DONE : ST_BUSY;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (last_step_s) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_BUSY;
          end
        end
        ST_DONE: state_s = ST_IDLE;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Output decode; reset and flush silence both handshake outputs.
  always_comb begin
    bus.request_stall = 1'b0;
    bus.done          = 1'b0;
    if (rst || bus.flush) begin
      bus.request_stall = 1'b0;
      bus.done          = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: bus.request_stall = bus.start;
        ST_BUSY: bus.request_stall = 1'b1;
        ST_DONE: bus.done          = 1'b1;
        default: bus.request_stall = 1'b0;
      endcase
    end
  end

  // Restoring step: the dividend shifts out of quo_r as quotient bits shift in.
  always_comb begin
    accept_s    = (state_r == ST_IDLE) && bus.start && !bus.flush;
    div_zero_s  = (bus.divisor == 32'd0);
    last_step_s = (count_r == LAST_STEP);
    shifted_s   = {rem_r, quo_r[DATA_W-1]};
    diff_s      = shifted_s - {1'b0, mag_b_r};
    if (!diff_s[DATA_W]) begin
      rem_next_s = diff_s[DATA_W-1:0];
      quo_next_s = {quo_r[DATA_W-2:0], 1'b1};
    end else begin
      rem_next_s = shifted_s[DATA_W-1:0];
      quo_next_s = {quo_r[DATA_W-2:0], 1'b0};
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= 6'd0;
      quo_r       <= 32'd0;
      rem_r       <= 32'd0;
      mag_b_r     <= 32'd0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      quotient_r  <= 32'd0;
      remainder_r <= 32'd0;
    end else if (accept_s) begin
      count_r <= 6'd0;
      rem_r   <= 32'd0;
      quo_r   <= cond_neg(bus.dividend, bus.signed_div & bus.dividend[DATA_W-1]);
      mag_b_r <= cond_neg(bus.divisor, bus.signed_div & bus.divisor[DATA_W-1]);
      q_neg_r <= bus.signed_div & (bus.dividend[DATA_W-1] ^ bus.divisor[DATA_W-1]);
      r_neg_r <= bus.signed_div & bus.dividend[DATA_W-1];
      if (div_zero_s) begin
        quotient_r  <= 32'hFFFF_FFFF;
        remainder_r <= bus.dividend;
      end else begin
        quotient_r  <= quotient_r;
        remainder_r <= remainder_r;
      end
    end else if ((state_r == ST_BUSY) && !bus.flush) begin
      count_r <= count_r + 6'd1;
      quo_r   <= quo_next_s;
      rem_r   <= rem_next_s;
      if (last_step_s) begin
        quotient_r  <= cond_neg(quo_next_s, q_neg_r);
        remainder_r <= cond_neg(rem_next_s, r_neg_r);
      end else begin
        quotient_r  <= quotient_r;
        remainder_r <= remainder_r;
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_multi_cycle_div.sv
// Directed bench for multi_cycle_div: latency, signed/unsigned results,
// divide-by-zero, overflow, flush, reset mid-divide and back-to-back starts.
module tb_multi_cycle_div;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  multi_cycle_div_if bus ();

  multi_cycle_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch one divide at a negedge and follow it until done (bounded).
  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input int exp_lat, input bit keep_start);
    int stall_cnt;
    int done_at;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    #1;
    stall_cnt = int'(bus.request_stall);
    done_at   = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (bus.done) begin
        done_at = c;
        break;
      end
      stall_cnt += int'(bus.request_stall);
    end
    check_val({tag, "_lat"},   32'(done_at),   32'(exp_lat));
    check_val({tag, "_stall"}, 32'(stall_cnt), 32'(exp_lat));
    check_val({tag, "_quo"},   bus.quotient,   exp_q);
    check_val({tag, "_rem"},   bus.remainder,  exp_r);
    if (!keep_start) bus.start = 1'b0;
  endtask

  initial begin
    int dones;
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.flush      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd5;
    bus.divisor    = 32'd1;
    repeat (2) @(negedge clk);
    check_val("rst_stall", 32'(bus.request_stall), 32'd0);
    check_val("rst_done",  32'(bus.done),          32'd0);
    check_val("rst_quo",   bus.quotient,           32'd0);
    check_val("rst_rem",   bus.remainder,          32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;

    run_div("u100_7",  1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          33, 1'b0);
    run_div("s_m7_2",  1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  33, 1'b0);
    run_div("s_7_m2",  1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33, 1'b0);
    run_div("u_max10", 1'b0, 32'hFFFF_FFFF,  32'd10,         32'h1999_9999,  32'd5,          33, 1'b0);
    run_div("dz_u",    1'b0, 32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h0000_1234,  1,  1'b0);
    run_div("dz_s",    1'b1, 32'hFFFF_FF00,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FF00,  1,  1'b0);
    run_div("ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33, 1'b0);

    // Flush in cycle N+10 of a running divide.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.dividend   = 32'd1000;
    bus.divisor    = 32'd3;
    dones = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    bus.flush = 1'b1;
    #1;
    check_val("fl_stall_n10", 32'(bus.request_stall), 32'd0);
    check_val("fl_done_n10",  32'(bus.done),          32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    dones += int'(bus.done);
    check_val("fl_stall_n11", 32'(bus.request_stall), 32'd0);
    check_val("fl_no_done",   32'(dones),             32'd0);
    check_val("fl_quo_hold",  bus.quotient,           32'h8000_0000);
    check_val("fl_rem_hold",  bus.remainder,          32'd0);
    run_div("after_fl", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33, 1'b0);

    // Reset in the middle of a divide.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 32'd77;
    bus.divisor  = 32'd4;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mrst_stall", 32'(bus.request_stall), 32'd0);
    check_val("mrst_done",  32'(bus.done),          32'd0);
    @(negedge clk);
    check_val("mrst_quo",   bus.quotient,           32'd0);
    check_val("mrst_rem",   bus.remainder,          32'd0);
    check_val("mrst_stall2", 32'(bus.request_stall), 32'd0);
    rst       = 1'b0;
    bus.start = 1'b0;

    // Back-to-back instructions with start never dropping.
    run_div("b2b_1", 1'b0, 32'd1000,       32'd3,          32'h0000_014D,  32'd1,          33, 1'b1);
    run_div("b2b_2", 1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  33, 1'b0);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      dones += int'(bus.done);
    end
    check_val("b2b_no_extra", 32'(dones), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
